// File: rtl/mq_decoder_if.sv
// Handshake bundle between the codestream byte fetcher, the context modeller and the MQ decoder.
interface mq_decoder_if;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [3:0] cx;
    logic       cx_valid;
    logic       cx_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;

    modport master (output start, byte_in, byte_valid, cx, cx_valid,
                    input  byte_ready, cx_ready, bit_out, bit_valid, busy);
    modport slave  (input  start, byte_in, byte_valid, cx, cx_valid,
                    output byte_ready, cx_ready, bit_out, bit_valid, busy);
endinterface

// File: rtl/mq_decoder.sv
// JPEG2000 MQ arithmetic decoder: turns a compressed byte stream plus context labels into decisions.
// One decision per cycle while no renormalisation is needed; renorm shifts one bit per cycle.
module mq_decoder #(
    parameter int NUM_CX = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    mq_decoder_if.slave bus
);
    localparam logic [15:0] QE_TAB [47] = '{
        16'h5601, 16'h3401, 16'h1801, 16'h0AC1, 16'h0521, 16'h0221, 16'h5601, 16'h5401,
        16'h4801, 16'h3801, 16'h3001, 16'h2401, 16'h1C01, 16'h1601, 16'h5601, 16'h5401,
        16'h5101, 16'h4801, 16'h3801, 16'h3401, 16'h3001, 16'h2801, 16'h2401, 16'h2201,
        16'h1C01, 16'h1801, 16'h1601, 16'h1401, 16'h1201, 16'h1101, 16'h0AC1, 16'h09C1,
        16'h08A1, 16'h0521, 16'h0441, 16'h02A1, 16'h0221, 16'h0141, 16'h0111, 16'h0085,
        16'h0049, 16'h0025, 16'h0015, 16'h0009, 16'h0005, 16'h0001, 16'h5601};
    localparam logic [5:0] NMPS_TAB [47] = '{
        1, 2, 3, 4, 5, 38, 7, 8, 9, 10, 11, 12, 13, 29, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24,
        25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 44, 45, 45, 46};
    localparam logic [5:0] NLPS_TAB [47] = '{
        1, 6, 9, 12, 29, 33, 6, 14, 14, 14, 17, 18, 20, 21, 14, 14, 15, 16, 17, 18, 19, 19, 20, 21,
        22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 46};
    localparam logic [46:0] SWITCH_TAB = 47'h0000_0000_4041;
    localparam logic [3:0]  NUM_CX_L   = 4'(NUM_CX);

    typedef enum logic [2:0] {IDLE, INIT0, INIT1, READY, RENORM, FILL} state_t;

    state_t      state;
    logic [15:0] a_q;
    logic [31:0] c_q;
    logic [3:0]  ct_q;
    logic [7:0]  b_q;
    logic        marker_q;
    logic [5:0]  idx_q [NUM_CX];
    logic        mps_q [NUM_CX];

    logic        bi_stall, bi_consume, bi_marker;
    logic [31:0] bi_c;
    logic [3:0]  bi_ct;
    logic [7:0]  bi_b;

    // BYTEIN: the register updates a fill would make this cycle, shared by INIT1 and FILL.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bi_stall   = 1'b0;
        bi_consume = 1'b0;
        bi_marker  = marker_q;
        bi_c       = c_q;
        bi_ct      = ct_q;
        bi_b       = b_q;
        if (marker_q) begin
            bi_c  = c_q + 32'h0000_FF00;
            bi_ct = 4'd8;
        end else if (!bus.byte_valid) begin
            bi_stall = 1'b1;
        end else if (b_q == 8'hFF) begin
            if (bus.byte_in > 8'h8F) begin
                bi_marker = 1'b1;
                bi_c      = c_q + 32'h0000_FF00;
                bi_ct     = 4'd8;
            end else begin
                bi_consume = 1'b1;
                bi_b       = bus.byte_in;
                bi_c       = c_q + {15'd0, bus.byte_in, 9'd0};
                bi_ct      = 4'd7;
            end
        end else begin
            bi_consume = 1'b1;
            bi_b       = bus.byte_in;
            bi_c       = c_q + {16'd0, bus.byte_in, 8'd0};
            bi_ct      = 4'd8;
        end
    end

    logic        cx_ok, cur_mps, dec_bit, dec_mps, dec_renorm;
    logic [3:0]  cx_sel;
    logic [5:0]  cur_idx, dec_idx;
    logic [15:0] qe, ad, dec_a, dec_chigh;

    always_comb begin
        cx_ok      = bus.cx < NUM_CX_L;
        cx_sel     = cx_ok ? bus.cx : 4'd0;
        cur_idx    = idx_q[cx_sel];
        cur_mps    = mps_q[cx_sel];
        qe         = QE_TAB[cur_idx];
        ad         = a_q - qe;
        dec_a      = ad;
        dec_chigh  = c_q[31:16] - qe;
        dec_idx    = NMPS_TAB[cur_idx];
        dec_mps    = cur_mps;
        dec_bit    = cur_mps;
        dec_renorm = 1'b1;
        if (c_q[31:16] < qe) begin
            dec_a     = qe;
            dec_chigh = c_q[31:16];
            if (ad >= qe) begin
                dec_bit = ~cur_mps;
                dec_idx = NLPS_TAB[cur_idx];
                dec_mps = cur_mps ^ SWITCH_TAB[cur_idx];
            end
        end else if (ad[15]) begin
            dec_idx    = cur_idx;
            dec_renorm = 1'b0;
        end else if (ad < qe) begin
            dec_bit = ~cur_mps;
            dec_idx = NLPS_TAB[cur_idx];
            dec_mps = cur_mps ^ SWITCH_TAB[cur_idx];
        end
    end

    // Consumption is acknowledged in the same cycle the byte is latched, so this stays combinational.
    assign bus.byte_ready = !bus.start &&
                            ((state == INIT0 && bus.byte_valid) ||
                             ((state == INIT1 || state == FILL) && bi_consume));

    // NOTE: state is updated only with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_q           <= 16'h8000;
            c_q           <= '0;
            ct_q          <= '0;
            b_q           <= '0;
            marker_q      <= 1'b0;
            bus.cx_ready  <= 1'b0;
            bus.bit_out   <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.busy      <= 1'b0;
            // NOTE: the context store is a small flop array, so it can be cleared by reset and start alike.
            for (int i = 0; i < NUM_CX; i++) begin
                idx_q[i] <= '0;
                mps_q[i] <= 1'b0;
            end
        end else begin
            bus.bit_valid <= 1'b0;
            if (bus.start) begin
                state        <= INIT0;
                marker_q     <= 1'b0;
                bus.busy     <= 1'b1;
                bus.cx_ready <= 1'b0;
                for (int i = 0; i < NUM_CX; i++) begin
                    idx_q[i] <= '0;
                    mps_q[i] <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: ;
                    INIT0: if (bus.byte_valid) begin
                        b_q   <= bus.byte_in;
                        c_q   <= {8'd0, bus.byte_in, 16'd0};
                        state <= INIT1;
                    end
                    INIT1: if (!bi_stall) begin
                        b_q          <= bi_b;
                        marker_q     <= bi_marker;
                        c_q          <= bi_c << 7;
                        ct_q         <= bi_ct - 4'd7;
                        a_q          <= 16'h8000;
                        state        <= READY;
                        bus.cx_ready <= 1'b1;
                    end
                    READY: if (bus.cx_valid) begin
                        bus.bit_valid <= 1'b1;
                        bus.bit_out   <= 1'b0;
                        if (cx_ok) begin
                            bus.bit_out    <= dec_bit;
                            a_q            <= dec_a;
                            c_q[31:16]     <= dec_chigh;
                            idx_q[cx_sel]  <= dec_idx;
                            mps_q[cx_sel]  <= dec_mps;
                            if (dec_renorm) begin
                                state        <= RENORM;
                                bus.cx_ready <= 1'b0;
                            end
                        end
                    end
                    RENORM: if (ct_q == 4'd0) begin
                        state <= FILL;
                    end else begin
                        a_q  <= {a_q[14:0], 1'b0};
                        c_q  <= {c_q[30:0], 1'b0};
                        ct_q <= ct_q - 4'd1;
                        if (a_q[14]) begin
                            state        <= READY;
                            bus.cx_ready <= 1'b1;
                        end
                    end
                    FILL: if (!bi_stall) begin
                        b_q      <= bi_b;
                        marker_q <= bi_marker;
                        c_q      <= bi_c;
                        ct_q     <= bi_ct;
                        state    <= RENORM;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mq_decoder.sv
// Self-checking bench for mq_decoder: a decision-level MQ decoding model plus hand-computed anchors.
module tb_mq_decoder;
    localparam int NUM_CX = 9;
    localparam int QE_T [47] = '{
        'h5601, 'h3401, 'h1801, 'h0AC1, 'h0521, 'h0221, 'h5601, 'h5401, 'h4801, 'h3801, 'h3001, 'h2401,
        'h1C01, 'h1601, 'h5601, 'h5401, 'h5101, 'h4801, 'h3801, 'h3401, 'h3001, 'h2801, 'h2401, 'h2201,
        'h1C01, 'h1801, 'h1601, 'h1401, 'h1201, 'h1101, 'h0AC1, 'h09C1, 'h08A1, 'h0521, 'h0441, 'h02A1,
        'h0221, 'h0141, 'h0111, 'h0085, 'h0049, 'h0025, 'h0015, 'h0009, 'h0005, 'h0001, 'h5601};
    localparam int NMPS_T [47] = '{
        1, 2, 3, 4, 5, 38, 7, 8, 9, 10, 11, 12, 13, 29, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24,
        25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 44, 45, 45, 46};
    localparam int NLPS_T [47] = '{
        1, 6, 9, 12, 29, 33, 6, 14, 14, 14, 17, 18, 20, 21, 14, 14, 15, 16, 17, 18, 19, 19, 20, 21,
        22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 46};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mq_decoder_if bus();
    mq_decoder #(.NUM_CX(NUM_CX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [7:0] stream [$];
    int pos = 0;
    int nbytes = 0;
    bit bv_en = 1'b1;
    int exp_bits [$];
    int last_exp;

    int unsigned m_a, m_c, m_b;
    int m_ct, m_pos;
    bit m_marker;
    int m_idx [NUM_CX];
    int m_mps [NUM_CX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.bit_valid === 1'b1) begin
            if (exp_bits.size() == 0) check("unexpected bit_valid", 32'd1, 32'd0);
            else check("bit_out vs model", 32'(bus.bit_out), 32'(exp_bits.pop_front()));
        end
        if (bus.byte_ready === 1'b1) check("byte_ready without byte_valid", 32'(bus.byte_valid), 32'd1);
    end

    function automatic void drive_bytes();
        bus.byte_valid = bv_en && (pos < stream.size());
        bus.byte_in    = (pos < stream.size()) ? stream[pos] : 8'h00;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bus.byte_ready === 1'b1) begin
            pos++;
            nbytes++;
        end
        @(posedge clk);
        #1;
        drive_bytes();
    endtask

    function automatic void load_zeros(input logic [7:0] first, input logic [7:0] second);
        stream.delete();
        stream.push_back(first);
        stream.push_back(second);
        for (int i = 0; i < 62; i++) stream.push_back(8'h00);
    endfunction

    // Decision-level model: plain Annex C procedures over the bench's own copy of the stream.
    function automatic void m_bytein();
        int unsigned nb;
        if (m_marker) begin
            m_c += 32'h0000_FF00;
            m_ct = 8;
            return;
        end
        nb = (m_pos < stream.size()) ? 32'(stream[m_pos]) : 0;
        if (m_b == 'hFF && nb > 'h8F) begin
            m_marker = 1'b1;
            m_c += 32'h0000_FF00;
            m_ct = 8;
        end else begin
            m_c += (m_b == 'hFF) ? (nb << 9) : (nb << 8);
            m_ct = (m_b == 'hFF) ? 7 : 8;
            m_b = nb;
            m_pos++;
        end
    endfunction

    function automatic void m_init();
        for (int i = 0; i < NUM_CX; i++) begin
            m_idx[i] = 0;
            m_mps[i] = 0;
        end
        m_marker = 1'b0;
        m_b = 32'(stream[0]);
        m_c = m_b << 16;
        m_pos = 1;
        m_bytein();
        m_c = m_c << 7;
        m_ct = m_ct - 7;
        m_a = 'h8000;
    endfunction

    function automatic int m_decode(input int cx);
        int unsigned qe, ad;
        int d, i;
        if (cx >= NUM_CX) return 0;
        i = m_idx[cx];
        qe = QE_T[i];
        ad = m_a - qe;
        if ((m_c >> 16) < qe) begin
            m_a = qe;
            if (ad < qe) begin
                d = m_mps[cx];
                m_idx[cx] = NMPS_T[i];
            end else begin
                d = 1 - m_mps[cx];
                m_idx[cx] = NLPS_T[i];
                if (i == 0 || i == 6 || i == 14) m_mps[cx] = 1 - m_mps[cx];
            end
        end else begin
            m_c = m_c - (qe << 16);
            m_a = ad;
            if ((ad & 'h8000) != 0) return m_mps[cx];
            if (ad < qe) begin
                d = 1 - m_mps[cx];
                m_idx[cx] = NLPS_T[i];
                if (i == 0 || i == 6 || i == 14) m_mps[cx] = 1 - m_mps[cx];
            end else begin
                d = m_mps[cx];
                m_idx[cx] = NMPS_T[i];
            end
        end
        do begin
            if (m_ct == 0) m_bytein();
            m_a = (m_a << 1) & 'hFFFF;
            m_c = m_c << 1;
            m_ct--;
        end while ((m_a & 'h8000) == 0);
        return d;
    endfunction

    task automatic do_start();
        pos = 0;
        nbytes = 0;
        drive_bytes();
        bus.start = 1'b1;
        m_init();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 300 && bus.cx_ready !== 1'b1; i++) tick();
        check({name, " cx_ready timeout"}, 32'(bus.cx_ready), 32'd1);
    endtask

    task automatic decide(input int cx);
        wait_ready("decide");
        bus.cx = 4'(cx);
        bus.cx_valid = 1'b1;
        last_exp = m_decode(cx);
        exp_bits.push_back(last_exp);
        tick();
        bus.cx_valid = 1'b0;
    endtask

    task automatic check_model(input string name);
        wait_ready(name);
        check({name, " A"}, 32'(dut.a_q), m_a);
        check({name, " C"}, dut.c_q, m_c);
        check({name, " CT"}, 32'(dut.ct_q), 32'(m_ct));
        check({name, " bytes"}, 32'(nbytes), 32'(m_pos));
        for (int i = 0; i < NUM_CX; i++) begin
            check($sformatf("%s idx[%0d]", name, i), 32'(dut.idx_q[i]), 32'(m_idx[i]));
            check($sformatf("%s mps[%0d]", name, i), 32'(dut.mps_q[i]), 32'(m_mps[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [31:0] sa, sc, sct;
        bus.start = 1'b0;
        bus.cx = 4'd0;
        bus.cx_valid = 1'b0;
        load_zeros(8'h00, 8'h00);
        drive_bytes();
        #1 rst_n = 1'b0;

        // Reset and idle, with byte_valid held high.
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {bus.bit_valid, bus.byte_ready, bus.cx_ready, bus.busy}, 4'b0);
        check("reset A", 32'(dut.a_q), 32'h8000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle outputs", {bus.bit_valid, bus.byte_ready, bus.cx_ready, bus.busy}, 4'b0);
        end
        check("idle consumed", 32'(nbytes), 32'd0);

        // Init on all-zero bytes, then a first LPS-exchange decision.
        do_start();
        check("init busy", 32'(bus.busy), 32'd1);
        wait_ready("s2 init");
        check("s2 bytes", 32'(nbytes), 32'd2);
        check("s2 C", dut.c_q, 32'h0);
        check("s2 CT", 32'(dut.ct_q), 32'd1);
        check("s2 A", 32'(dut.a_q), 32'h8000);
        decide(0);
        check("s2 model bit", 32'(last_exp), 32'd0);
        wait_ready("s2 dec");
        check("s2 A after", 32'(dut.a_q), 32'hAC02);
        check("s2 CT after", 32'(dut.ct_q), 32'd0);
        check("s2 idx0", 32'(dut.idx_q[0]), 32'd1);
        check("s2 mps0", 32'(dut.mps_q[0]), 32'd0);
        check("s2 bytes after", 32'(nbytes), 32'd2);
        foreach (stream[i]) stream[i] = 8'((i * 41 + 7) & 8'h3F);
        for (int k = 0; k < 12; k++) decide((k * 7) % 16);
        check_model("s2 mixed");

        // MPS exchange on C0,00,00.
        load_zeros(8'hC0, 8'h00);
        do_start();
        wait_ready("s3 init");
        check("s3 C", dut.c_q, 32'h6000_0000);
        decide(0);
        check("s3 Chigh", 32'(dut.c_q[31:16]), 32'h09FF);
        check("s3 mps0", 32'(dut.mps_q[0]), 32'd1);
        check("s3 idx0", 32'(dut.idx_q[0]), 32'd1);
        check("s3 model bit", 32'(last_exp), 32'd1);
        wait_ready("s3 dec");
        check("s3 A", 32'(dut.a_q), 32'hA7FC);
        check("s3 bytes", 32'(nbytes), 32'd3);
        check_model("s3");

        // Longer run over a varied stream with stuffed 0xFF bytes and out-of-range contexts.
        stream.delete();
        for (int i = 0; i < 256; i++) begin
            if (i % 23 == 7) stream.push_back(8'hFF);
            else if (i % 23 == 8) stream.push_back(8'((i * 5) & 8'h7F));
            else stream.push_back(8'(i * 73 + 29));
        end
        do_start();
        for (int k = 0; k < 40; k++) decide((k * 5 + k / 3) % 11);
        check_model("mix a");
        for (int k = 0; k < 40; k++) decide((k * 3 + 1) % 9);
        check_model("mix b");
        check("pending bits", 32'(exp_bits.size()), 32'd0);

        // Marker at init: FF then 0x91 is never consumed.
        load_zeros(8'hFF, 8'h91);
        do_start();
        wait_ready("s4 init");
        check("s4 bytes", 32'(nbytes), 32'd1);
        check("s4 C", dut.c_q, 32'h7FFF_8000);
        check("s4 CT", 32'(dut.ct_q), 32'd1);
        decide(0);
        check("s4 model bit", 32'(last_exp), 32'd1);
        wait_ready("s4 dec");
        check("s4 C after", dut.c_q, 32'hA7FB_FE00);
        check("s4 CT after", 32'(dut.ct_q), 32'd7);
        for (int k = 0; k < 20; k++) decide(k % 4);
        check_model("s4 marker");
        check("s4 bytes after", 32'(nbytes), 32'd1);

        // Stuffed byte below the marker range is consumed with a 7-bit fill.
        load_zeros(8'hFF, 8'h7F);
        do_start();
        wait_ready("s4b init");
        check("s4b C", dut.c_q, 32'h7FFF_0000);
        check("s4b CT", 32'(dut.ct_q), 32'd0);
        check("s4b bytes", 32'(nbytes), 32'd2);
        for (int k = 0; k < 10; k++) decide(k % 3);
        check_model("s4b");

        // Stall in FILL while byte_valid is low.
        load_zeros(8'h00, 8'h00);
        do_start();
        decide(0);
        wait_ready("s5 first");
        bv_en = 1'b0;
        drive_bytes();
        decide(0);
        check("s5 model bit", 32'(last_exp), 32'd1);
        tick();
        n0 = nbytes;
        sa = 32'(dut.a_q);
        sc = dut.c_q;
        sct = 32'(dut.ct_q);
        check("s5 A at stall", sa, 32'h3401);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s5 A frozen", 32'(dut.a_q), sa);
            check("s5 C frozen", dut.c_q, sc);
            check("s5 CT frozen", 32'(dut.ct_q), sct);
            check("s5 cx_ready", 32'(bus.cx_ready), 32'd0);
        end
        check("s5 no consume", 32'(nbytes), 32'(n0));
        bv_en = 1'b1;
        drive_bytes();
        tick();
        check("s5 resume consume", 32'(nbytes), 32'(n0 + 1));
        check_model("s5");

        // Abort during RENORM, then the first decision must repeat the all-zero result.
        load_zeros(8'hC0, 8'h00);
        do_start();
        decide(0);
        load_zeros(8'h00, 8'h00);
        do_start();
        check("s6 idx0 cleared", 32'(dut.idx_q[0]), 32'd0);
        check("s6 mps0 cleared", 32'(dut.mps_q[0]), 32'd0);
        check("s6 cx_ready", 32'(bus.cx_ready), 32'd0);
        decide(0);
        check("s6 model bit", 32'(last_exp), 32'd0);
        wait_ready("s6 dec");
        check("s6 A", 32'(dut.a_q), 32'hAC02);
        check("s6 idx0", 32'(dut.idx_q[0]), 32'd1);
        check("s6 bytes", 32'(nbytes), 32'd2);

        // start and cx_valid together: start wins, no decision.
        bus.cx = 4'd0;
        bus.cx_valid = 1'b1;
        do_start();
        bus.cx_valid = 1'b0;
        check("start wins bit_valid", 32'(bus.bit_valid), 32'd0);
        check("start wins busy", 32'(bus.busy), 32'd1);
        check_model("start wins");

        // Asynchronous reset in the middle of a renorm.
        decide(0);
        #2 rst_n = 1'b0;
        #1;
        exp_bits.delete();
        check("async rst outputs", {bus.bit_valid, bus.cx_ready, bus.busy}, 3'b0);
        check("async rst A", 32'(dut.a_q), 32'h8000);
        check("async rst C", dut.c_q, 32'h0);
        check("async rst idx0", 32'(dut.idx_q[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post rst idle", {bus.byte_ready, bus.cx_ready, bus.busy}, 3'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
